// File: rtl/usart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width
// and the baud-timing helper used by both directions of the link.
package usart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } usart_state_t;

  // Clock cycles per bit and per half bit.
  typedef struct packed {
    logic [31:0] bit_cnt;
    logic [31:0] half;
  } usart_timing_t;

  function automatic usart_timing_t usart_calc_timing(input int unsigned clk_freq,
                                                      input int unsigned baud);
    usart_timing_t t;
    t.bit_cnt = clk_freq / baud;
    t.half    = t.bit_cnt / 2;
    return t;
  endfunction

endpackage

// File: rtl/usart_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both stages reset to 1 so a reset never looks like a start bit.
module usart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous input, then re-register to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/usart_rx.sv
// UART receiver, 8N1 by default. Defining USART_RX_PARITY_EN switches to 8E1
// framing: an even-parity bit follows bit 7 and the par_err port appears.
//
// Output handshake: rs_rdy is a one-cycle strobe with no back-pressure; data
// is valid in the rs_rdy cycle and holds until the next good frame. frm_err
// and par_err are one-cycle strobes; par_err only ever fires with rs_rdy.
module usart_rx
  import usart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data,
  output logic              rs_ing,
  output logic              rs_rdy,
  output logic              frm_err,
`ifdef USART_RX_PARITY_EN
  output logic              par_err,
`endif
  output usart_state_t      dbg_state
);

  localparam usart_timing_t TIMING   = usart_calc_timing(CLK_FREQ, BAUD);
  localparam int unsigned   BIT_CNT  = TIMING.bit_cnt;
  localparam int unsigned   HALF     = TIMING.half;
  localparam int            CNT_W    = $clog2(BIT_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef USART_RX_PARITY_EN
  localparam usart_state_t AFTER_DATA = PARITY;
`else
  localparam usart_state_t AFTER_DATA = STOP;
`endif

  logic              w_rxs;
  logic              r_rxs_d;
  logic              w_fall;

  usart_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_rdy, w_rdy_nxt;
  logic              r_ferr, w_ferr_nxt;
`ifdef USART_RX_PARITY_EN
  logic              r_par, w_par_nxt;
  logic              r_perr, w_perr_nxt;
`endif

  usart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_bit),
    .o_q   (w_rxs)
  );

  assign w_fall = r_rxs_d & ~w_rxs;

  // State, timing counter, shift register and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxs_d <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef USART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_rxs_d <= w_rxs;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_rdy   <= w_rdy_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef USART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Frame sequencing: every bit is sampled once the counter reaches mid-bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_rdy_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef USART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          // A line that is high again at mid start bit was only a glitch.
          w_state_nxt = w_rxs ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rxs;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = AFTER_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
`ifdef USART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rxs;
          w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_data_nxt  = r_shift;
            w_rdy_nxt   = 1'b1;
`ifdef USART_RX_PARITY_EN
            w_perr_nxt  = ^{r_shift, r_par};
`endif
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        // Hold off while the line is low (break) so it is not read as starts.
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign rs_rdy    = r_rdy;
  assign frm_err   = r_ferr;
`ifdef USART_RX_PARITY_EN
  assign par_err   = r_perr;
`endif
  assign rs_ing    = (r_state == START) || (r_state == DATA) ||
                     (r_state == PARITY) || (r_state == STOP);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx (8N1, or 8E1 when USART_RX_PARITY_EN is defined).
module tb_usart_rx;
  import usart_pkg::*;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 115200;
  localparam int BIT_CNT = 434;
  localparam int HALF    = 217;
`ifdef USART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Cycles rs_ing stays high for a complete frame: half start bit plus the
  // remaining bit periods up to the stop-bit sample.
  localparam int FRAME_RUN = HALF + (9 + PAR_BITS) * BIT_CNT;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_bit = 1'b1;
  logic [7:0] data;
  logic rs_ing, rs_rdy, frm_err;
`ifdef USART_RX_PARITY_EN
  logic par_err;
`endif
  usart_state_t dbg_state;

  always #10 clk = ~clk;

  usart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_bit    (rx_bit),
    .data      (data),
    .rs_ing    (rs_ing),
    .rs_rdy    (rs_rdy),
    .frm_err   (frm_err),
`ifdef USART_RX_PARITY_EN
    .par_err   (par_err),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];        // {expected par_err, expected data}
  int exp_ferr = 0;
  int got_ferr = 0;
  int got_rdy = 0;
  int got_perr = 0;
  int run_len = 0;
  int last_run = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- output monitor ----------------
  logic       prev_rdy = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8:0] mon_e;

  // Pops the expected queue on each rs_rdy and checks pulse shape/timing.
  always @(negedge clk) begin
    if (rs_ing) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (rs_rdy) begin
      got_rdy++;
      check("rdy_width", {31'd0, prev_rdy}, 32'd0);
      check("rdy_timing", last_run, FRAME_RUN);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rdy_unexpected actual=data 0x%0h required=no pulse", data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdy_data", {24'd0, data}, {24'd0, mon_e[7:0]});
`ifdef USART_RX_PARITY_EN
        check("rdy_par_err", {31'd0, par_err}, {31'd0, mon_e[8]});
`endif
      end
    end
`ifdef USART_RX_PARITY_EN
    if (par_err) begin
      got_perr++;
      check("perr_with_rdy", {31'd0, rs_rdy}, 32'd1);
    end
`endif
    if (frm_err) begin
      got_ferr++;
      check("ferr_timing", last_run, FRAME_RUN);
      check("ferr_no_rdy", {31'd0, rs_rdy}, 32'd0);
    end
    if (rst_n && prev_rst && (data !== prev_data))
      check("data_change_with_rdy", {31'd0, rs_rdy}, 32'd1);
    prev_rdy  = rs_rdy;
    prev_rst  = rst_n;
    prev_data = data;
  end

  // ---------------- drivers and reference model ----------------
  task automatic drive(input logic v, input int n);
    rx_bit = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    drive(1'b0, BIT_CNT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CNT);
`ifdef USART_RX_PARITY_EN
    drive(par, BIT_CNT);
`else
    if (par) begin end
`endif
    drive(stop, BIT_CNT);
  endtask

  // Frame-level rule: good stop delivers the byte (parity error flagged if
  // byte plus parity bit is odd); a low stop bit is a framing error only.
  task automatic expect_frame(input logic [7:0] b, input logic stop, input logic par);
    logic perr;
    perr = (PAR_BITS != 0) ? ^{b, par} : 1'b0;
    if (stop) begin
      exp_q.push_back({perr, b});
      last_good = b;
    end else begin
      exp_ferr++;
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  typedef struct {
    logic [7:0] b_val;
    logic       stop;
    int         hold_low;
    int         gap;
    int         exp_rdy;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  int r0, f0, gap;
  logic [7:0] rb;
  logic rstop, rpar;
  logic [7:0] abort_b;

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,           20, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,           0,  1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,           20, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 2 * BIT_CNT, 20, 0, 1, 8'hFF};
    vecs[4] = '{8'h96, 1'b1, 0,           20, 1, 0, 8'h96};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_rs_ing", {31'd0, rs_ing}, 32'd0);
    check("reset_rs_rdy", {31'd0, rs_rdy}, 32'd0);
    check("reset_frm_err", {31'd0, frm_err}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // Table: good frames, back-to-back, framing error with held-low line.
    for (int i = 0; i < 5; i++) begin
      r0 = got_rdy;
      f0 = got_ferr;
      expect_frame(vecs[i].b_val, vecs[i].stop, even_par(vecs[i].b_val));
      send_frame(vecs[i].b_val, vecs[i].stop, even_par(vecs[i].b_val));
      if (vecs[i].hold_low != 0) drive(1'b0, vecs[i].hold_low);
      check($sformatf("vec%0d_rdy_cnt", i), got_rdy - r0, vecs[i].exp_rdy);
      check($sformatf("vec%0d_ferr_cnt", i), got_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
      if (vecs[i].gap != 0) drive(1'b1, vecs[i].gap);
    end

    // Short low glitch on idle line: false start, rs_ing high for HALF cycles.
    r0 = got_rdy;
    f0 = got_ferr;
    drive(1'b0, 100);
    drive(1'b1, BIT_CNT);
    check("glitch_run", last_run, HALF);
    check("glitch_rs_ing", {31'd0, rs_ing}, 32'd0);
    check("glitch_rdy_cnt", got_rdy - r0, 0);
    check("glitch_ferr_cnt", got_ferr - f0, 0);

    // Reset in the middle of data bit 4, then a clean frame.
    r0 = got_rdy;
    f0 = got_ferr;
    abort_b = 8'hC3;
    drive(1'b0, BIT_CNT);
    for (int i = 0; i < 4; i++) drive(abort_b[i], BIT_CNT);
    drive(abort_b[4], HALF);
    rst_n = 1'b0;
    rx_bit = 1'b1;
    @(negedge clk);
    check("abort_rs_ing", {31'd0, rs_ing}, 32'd0);
    check("abort_data", {24'd0, data}, 32'd0);
    check("abort_state", {29'd0, dbg_state}, {29'd0, IDLE});
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    drive(1'b1, BIT_CNT);
    check("abort_rdy_cnt", got_rdy - r0, 0);
    check("abort_ferr_cnt", got_ferr - f0, 0);
    expect_frame(8'h5A, 1'b1, even_par(8'h5A));
    send_frame(8'h5A, 1'b1, even_par(8'h5A));
    drive(1'b1, 20);
    check("after_abort_data", {24'd0, data}, 32'h5A);
    check("after_abort_pending", exp_q.size(), 0);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 4; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rpar  = (PAR_BITS != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      r0 = got_rdy;
      f0 = got_ferr;
      expect_frame(rb, rstop, rpar);
      send_frame(rb, rstop, rpar);
      check($sformatf("rand%0d_rdy_cnt", n), got_rdy - r0, rstop ? 1 : 0);
      check($sformatf("rand%0d_ferr_cnt", n), got_ferr - f0, rstop ? 0 : 1);
      check($sformatf("rand%0d_data", n), {24'd0, data}, {24'd0, last_good});
      check($sformatf("rand%0d_pending", n), exp_q.size(), 0);
      gap = rstop ? $urandom_range(0, 60) : $urandom_range(10, 60);
      if (gap != 0) drive(1'b1, gap);
    end

`ifdef USART_RX_PARITY_EN
    // Wrong parity still delivers data but flags par_err; correct parity does not.
    r0 = got_perr;
    expect_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    drive(1'b1, 20);
    check("par_bad_perr_cnt", got_perr - r0, 1);
    check("par_bad_data", {24'd0, data}, 32'h07);
    r0 = got_perr;
    expect_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    drive(1'b1, 20);
    check("par_good_perr_cnt", got_perr - r0, 0);
    check("par_good_data", {24'd0, data}, 32'h07);
`endif

    check("final_pending", exp_q.size(), 0);
    check("final_ferr_total", got_ferr, exp_ferr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
